// File: rtl/ram_partition_power_seq.sv
// ram_partition_power_seq
//   Owns the partition gating of one partitioned RAM (free list, PRF, ...).
//   A new active-partition mask is taken from the power-config logic. The
//   sequencer then drains the pipeline, applies the gating and waits for the
//   partitions to settle. It fills every newly enabled partition through the
//   init write port and finally reports the RAM ready again. Partition 0 is
//   never gated.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-low reset
//   cfgValid_i       request a new active-partition mask (taken only in idle)
//   cfgMask_i        requested mask, 1 = active
//   cfgReady_o       sequencer idle
//   drainReq_o       asks the pipeline to stop issuing RAM accesses
//   drainAck_i       pipeline quiescent (level, sampled while draining)
//   partitionGated_o to RAM partitionGated_i, 1 = gated
//   initWrEn_o       init write strobe (highest-numbered RAM write port)
//   initAddr_o       init write address {partition, offset}
//   initData_o       init write data
//   ramReady_o       RAM contents valid and configuration stable
module ram_partition_power_seq #(
  parameter int DEPTH         = 128,
  parameter int INDEX         = 7,
  parameter int WIDTH         = 32,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int INIT_SEQ      = 0,
  parameter int SEQ_START     = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfgValid_i,
  input  logic [NUM_PARTS-1:0] cfgMask_i,
  output logic                 cfgReady_o,
  output logic                 drainReq_o,
  input  logic                 drainAck_i,
  output logic [NUM_PARTS-1:0] partitionGated_o,
  output logic                 initWrEn_o,
  output logic [INDEX-1:0]     initAddr_o,
  output logic [WIDTH-1:0]     initData_o,
  output logic                 ramReady_o
);

  localparam int OFF_W = INDEX - NUM_PARTS_LOG;
  localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(DEPTH / NUM_PARTS - 1);
  localparam logic [OFF_W-1:0] SETTLE_LAST = OFF_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, GATE, SETTLE, INIT} stateT;

  stateT                state, stateNext;
  logic [NUM_PARTS-1:0] curMask, curMaskNext;
  logic [NUM_PARTS-1:0] newMask, newMaskNext;
  logic [NUM_PARTS-1:0] initPend, initPendNext;
  logic [OFF_W-1:0]     ctr, ctrNext;
  logic [NUM_PARTS-1:0] reqMask;
  logic [NUM_PARTS-1:0] gatedNext;
  logic                 wrEnNext;
  logic [INDEX-1:0]     addrNext;
  logic [WIDTH-1:0]     dataNext;

  // Index of the lowest set bit; partitions are filled in ascending order.
  function automatic logic [NUM_PARTS_LOG-1:0] lowestSet(input logic [NUM_PARTS-1:0] v);
    logic [NUM_PARTS_LOG-1:0] idx;
    idx = '0;
    for (int i = NUM_PARTS - 1; i >= 0; i--) begin
      if (v[i]) idx = NUM_PARTS_LOG'(i);
    end
    return idx;
  endfunction

  always_comb begin
    stateNext    = state;
    curMaskNext  = curMask;
    newMaskNext  = newMask;
    initPendNext = initPend;
    ctrNext      = ctr;
    gatedNext    = partitionGated_o;
    addrNext     = initAddr_o;
    dataNext     = initData_o;
    // Partition 0 always stays powered.
    reqMask      = cfgMask_i | NUM_PARTS'(1);

    case (state)
      IDLE: begin
        if (cfgValid_i && (reqMask != curMask)) begin
          newMaskNext  = reqMask;
          initPendNext = reqMask & ~curMask;
          stateNext    = DRAIN;
        end
      end
      DRAIN: begin
        if (drainAck_i) begin
          // Gating is applied on entry to GATE so it is visible right after the ack.
          gatedNext = ~newMask;
          stateNext = GATE;
        end
      end
      GATE: begin
        curMaskNext = newMask;
        ctrNext     = '0;
        stateNext   = (initPend == '0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        if (ctr == SETTLE_LAST) begin
          ctrNext   = '0;
          stateNext = INIT;
        end else begin
          ctrNext = ctr + OFF_W'(1);
        end
      end
      INIT: begin
        // ctr holds the offset of the write currently on the port; it wraps
        // to 0 naturally because a partition spans exactly 2**OFF_W entries.
        ctrNext = ctr + OFF_W'(1);
        if (ctr == OFF_LAST) begin
          initPendNext = initPend & ~(NUM_PARTS'(1) << lowestSet(initPend));
          if (initPendNext == '0) stateNext = IDLE;
        end
      end
      default: stateNext = SETTLE;
    endcase

    // Outputs are registered and describe the state being entered.
    wrEnNext = (stateNext == INIT);
    if (wrEnNext) begin
      addrNext = {lowestSet(initPendNext), ctrNext};
      dataNext = (INIT_SEQ != 0) ? (WIDTH'(SEQ_START) + WIDTH'(addrNext)) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Reset restarts a full fill of every partition without a drain handshake.
      state            <= SETTLE;
      curMask          <= '1;
      newMask          <= '1;
      initPend         <= '1;
      ctr              <= '0;
      partitionGated_o <= '0;
      drainReq_o       <= 1'b1;
      ramReady_o       <= 1'b0;
      cfgReady_o       <= 1'b0;
      initWrEn_o       <= 1'b0;
      initAddr_o       <= '0;
      initData_o       <= '0;
    end else begin
      state            <= stateNext;
      curMask          <= curMaskNext;
      newMask          <= newMaskNext;
      initPend         <= initPendNext;
      ctr              <= ctrNext;
      partitionGated_o <= gatedNext;
      drainReq_o       <= (stateNext != IDLE);
      ramReady_o       <= (stateNext == IDLE);
      cfgReady_o       <= (stateNext == IDLE);
      initWrEn_o       <= wrEnNext;
      initAddr_o       <= addrNext;
      initData_o       <= dataNext;
    end
  end

endmodule
